// File: rtl/lcd_spi_write.sv
// Mode-0 SPI byte writer for the LCD path with separate D/C line and wr_done handshake.
// Optional build macro LCD_SPI_CS_HOLD_EN keeps CS low across back-to-back words.
module lcd_spi_write #(
  parameter int CLK_DIV    = 2,
  parameter int GAP_CYCLES = 2
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       en_write,
  input  logic [8:0] data,
  output logic       busy,
  output logic       wr_done,
  output logic       lcd_sclk,
  output logic       lcd_mosi,
  output logic       lcd_dc,
  output logic       lcd_cs
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  logic [1:0]       state;
  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       bit_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [6:0]       shreg;
  logic             phase_end;

  // Bit 7 is presented directly on accept, so only the remaining seven bits are held.
  assign phase_end = (div_cnt == DIV_LAST);

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      shreg    <= '0;
      wr_done  <= 1'b0;
      lcd_sclk <= 1'b0;
      lcd_mosi <= 1'b0;
      lcd_dc   <= 1'b0;
      lcd_cs   <= 1'b1;
    end else begin
      wr_done <= 1'b0;
      case (state)
        IDLE: begin
          if (en_write) begin
            shreg    <= data[6:0];
            lcd_mosi <= data[7];
            lcd_dc   <= data[8];
            lcd_cs   <= 1'b0;
            lcd_sclk <= 1'b0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            state    <= SHIFT;
          end
`ifdef LCD_SPI_CS_HOLD_EN
          else begin
            lcd_cs <= 1'b1;
          end
`endif
        end

        SHIFT: begin
          if (!phase_end) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (!lcd_sclk) begin
              lcd_sclk <= 1'b1;
            end else begin
              lcd_sclk <= 1'b0;
              // Last bit: MOSI keeps bit 0 instead of shifting in a filler zero.
              if (bit_cnt == 3'd7) begin
                wr_done <= 1'b1;
                bit_cnt <= '0;
                gap_cnt <= '0;
                state   <= GAP;
`ifndef LCD_SPI_CS_HOLD_EN
                lcd_cs  <= 1'b1;
`endif
              end else begin
                bit_cnt  <= bit_cnt + 1'b1;
                lcd_mosi <= shreg[6];
                shreg    <= {shreg[5:0], 1'b0};
              end
            end
          end
        end

        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            state   <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_spi_write.sv
// Directed bench for lcd_spi_write: default instance plus a CLK_DIV=1/GAP_CYCLES=1 instance.
module tb_lcd_spi_write;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, en1;
  logic [8:0] din, din1;
  logic busy, done, sclk, mosi, dc, cs;
  logic busy1, done1, sclk1, mosi1, dc1, cs1;

  lcd_spi_write #(.CLK_DIV(2), .GAP_CYCLES(2)) dut (
    .sys_clk(clk), .sys_rst(rst), .en_write(en), .data(din),
    .busy(busy), .wr_done(done), .lcd_sclk(sclk), .lcd_mosi(mosi),
    .lcd_dc(dc), .lcd_cs(cs)
  );

  lcd_spi_write #(.CLK_DIV(1), .GAP_CYCLES(1)) dut1 (
    .sys_clk(clk), .sys_rst(rst), .en_write(en1), .data(din1),
    .busy(busy1), .wr_done(done1), .lcd_sclk(sclk1), .lcd_mosi(mosi1),
    .lcd_dc(dc1), .lcd_cs(cs1)
  );

  int checks = 0;
  int errors = 0;
  int cyc, nrise, rise_bad, done_cnt, done_cyc, done1_cnt;
  logic [7:0] cap, cap1;
  logic sclk_prev, sclk1_prev, cs35;
  logic busy_log [64];
  logic cs_log [64];
  logic busy1_log [64];
  logic done1_log [64];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    cyc = 0; nrise = 0; rise_bad = 0; done_cnt = 0; done_cyc = -1; done1_cnt = 0;
    cap = '0; cap1 = '0;
    sclk_prev = sclk; sclk1_prev = sclk1;
    for (int i = 0; i < 64; i++) begin
      busy_log[i] = 1'b0; cs_log[i] = 1'b0; busy1_log[i] = 1'b0; done1_log[i] = 1'b0;
    end
  endtask

  // One clock; outputs sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc < 64) begin
      busy_log[cyc] = busy; cs_log[cyc] = cs;
      busy1_log[cyc] = busy1; done1_log[cyc] = done1;
    end
    if (sclk && !sclk_prev) begin
      if (cyc != 3 + 4 * nrise) rise_bad++;
      cap = {cap[6:0], mosi};
      nrise++;
    end
    sclk_prev = sclk;
    if (sclk1 && !sclk1_prev) cap1 = {cap1[6:0], mosi1};
    sclk1_prev = sclk1;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (done1) done1_cnt++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  initial begin
    // Reset with en_write also high: reset must win.
    rst = 1'b1; en = 1'b1; din = 9'h1FF; en1 = 1'b0; din1 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_dc", dc, 0);
    check("rst_cs", cs, 1);
    rst = 1'b0; en = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Command byte 0x2A
    clear_stats();
    en = 1'b1; din = 9'h02A;
    step(); en = 1'b0;
    check("b1_cs_low", cs, 0);
    check("b1_dc", dc, 0);
    check("b1_mosi_first", mosi, 0);
    run_to(36);
    check("b1_byte", cap, 8'h2A);
    check("b1_nrise", nrise, 8);
    check("b1_rise_timing", rise_bad, 0);
    check("b1_done_cnt", done_cnt, 1);
    check("b1_done_cyc", done_cyc, 33);
    check("b1_busy_1", busy_log[1], 1);
    check("b1_busy_34", busy_log[34], 1);
    check("b1_busy_35", busy_log[35], 0);
`ifdef LCD_SPI_CS_HOLD_EN
    check("b1_cs_33", cs_log[33], 0);
`else
    check("b1_cs_33", cs_log[33], 1);
`endif
    check("b1_cs_36", cs_log[36], 1);

    // Data byte 0x1EF
    clear_stats();
    en = 1'b1; din = 9'h1EF;
    step(); en = 1'b0;
    check("b2_dc", dc, 1);
    check("b2_mosi_first", mosi, 1);
    run_to(36);
    check("b2_byte", cap, 8'hEF);
    check("b2_done_cyc", done_cyc, 33);
    check("b2_dc_hold", dc, 1);
    check("b2_mosi_hold", mosi, 1);

    // Back-to-back with en_write held; data changes during GAP
    clear_stats();
    en = 1'b1; din = 9'h0A5;
    run_to(34);
    din = 9'h100;
    check("b3_byte", cap, 8'hA5);
    check("b3_done_cyc", done_cyc, 33);
    step();
    cs35 = cs;
`ifdef LCD_SPI_CS_HOLD_EN
    check("b3_cs_33", cs_log[33], 0);
    check("b3_cs_34", cs_log[34], 0);
    check("b3_cs_35", cs35, 0);
`else
    check("b3_cs_33", cs_log[33], 1);
    check("b3_cs_34", cs_log[34], 1);
    check("b3_cs_35", cs35, 1);
`endif
    clear_stats();
    step(); en = 1'b0;
    check("b4_cs_low", cs, 0);
    check("b4_dc", dc, 1);
    check("b4_busy", busy, 1);
    run_to(34);
    check("b4_byte", cap, 8'h00);
    check("b4_done_cyc", done_cyc, 33);
    run_to(40);

    // en_write pulses during SHIFT and GAP are ignored
    clear_stats();
    en = 1'b1; din = 9'h0C3;
    step(); en = 1'b0;
    run_to(5); en = 1'b1; step(); en = 1'b0;
    run_to(34); en = 1'b1; step(); en = 1'b0;
    run_to(40);
    check("ign_done_cnt", done_cnt, 1);
    check("ign_byte", cap, 8'hC3);
    check("ign_busy_36", busy_log[36], 0);
    check("ign_busy_40", busy_log[40], 0);

    // Reset mid-byte
    clear_stats();
    en = 1'b1; din = 9'h155;
    step(); en = 1'b0;
    run_to(10);
    rst = 1'b1;
    step(); rst = 1'b0;
    check("mid_rst_cs", cs, 1);
    check("mid_rst_sclk", sclk, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_dc", dc, 0);
    run_to(50);
    check("mid_rst_no_done", done_cnt, 0);
    clear_stats();
    en = 1'b1; din = 9'h136;
    step(); en = 1'b0;
    run_to(36);
    check("post_rst_byte", cap, 8'h36);
    check("post_rst_dc", dc, 1);
    check("post_rst_done_cyc", done_cyc, 33);

    // CLK_DIV=1, GAP_CYCLES=1 instance with en_write held
    clear_stats();
    en1 = 1'b1; din1 = 9'h0B4;
    run_to(17);
    check("fast_done_17", done1_log[17], 1);
    check("fast_done_cnt1", done1_cnt, 1);
    check("fast_byte", cap1, 8'hB4);
    check("fast_busy_17", busy1_log[17], 1);
    step();
    check("fast_busy_18", busy1, 0);
    step(); en1 = 1'b0;
    check("fast_busy_19", busy1, 1);
    run_to(36);
    check("fast_done_35", done1_log[35], 1);
    check("fast_done_cnt2", done1_cnt, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
